// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic decode matrix.
// Holds the control FSM state encoding used by the shared controller.
package stoch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/stoch_decode.sv
// One matrix element: counts ones of its stochastic bit stream over a window
// and holds the final count until the next load.
module stoch_decode #(
  parameter int COUNT_BITS = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  load,
  input  logic                  a,
  output logic [COUNT_BITS:0]   y
);

  logic [COUNT_BITS:0] acc_reg;
  logic [COUNT_BITS:0] acc_plus;

  // One extra bit so a full window of ones (W) fits without wrapping.
  assign acc_plus = acc_reg + {{COUNT_BITS{1'b0}}, a};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_reg <= '0;
      y       <= '0;
    end else begin
      if (clear) begin
        acc_reg <= '0;
      end else if (enable) begin
        acc_reg <= acc_plus;
      end
      if (load) begin
        y <= acc_plus;
      end
    end
  end

endmodule

// File: rtl/stoch_decode_mat.sv
// Matrix of stochastic-to-binary decoders sharing one control FSM and one
// window counter; results are handed off with a valid/ready handshake.
module stoch_decode_mat
  import stoch_pkg::*;
#(
  parameter int NUM_ROWS   = 2,
  parameter int NUM_COLS   = 2,
  parameter int COUNT_BITS = 8
) (
  input  logic                                             CLK,
  input  logic                                             nRST,
  input  logic                                             start,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                A,
  input  logic                                             out_ready,
  output logic                                             busy,
  output logic                                             out_valid,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][COUNT_BITS:0]  Y
);

  state_t                state_reg;
  logic [COUNT_BITS-1:0] cnt_reg;
  logic                  busy_reg;
  logic                  valid_reg;
  logic                  window_last;
  logic                  clear;
  logic                  enable;
  logic                  load;

  assign window_last = (cnt_reg == {COUNT_BITS{1'b1}});
  assign clear       = (state_reg == IDLE) && start;
  assign enable      = (state_reg == ACCUM);
  assign load        = enable && window_last;

  assign busy      = busy_reg;
  assign out_valid = valid_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= ACCUM;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ACCUM: begin
          // Counter wraps back to 0 on the last window cycle by itself.
          cnt_reg <= cnt_reg + 1'b1;
          if (window_last) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
      stoch_decode #(
        .COUNT_BITS (COUNT_BITS)
      ) u_dec (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (clear),
        .enable (enable),
        .load   (load),
        .a      (A[gi][gj]),
        .y      (Y[gi][gj])
      );
    end
  end

endmodule

// File: tb/tb_stoch_decode_mat.sv
// Randomized bench for stoch_decode_mat: a window-level reference model is
// compared every cycle, plus fixed-pattern windows with literal expectations.
module tb_stoch_decode_mat;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int CB = 4;
  localparam int W  = 1 << CB;

  typedef logic [R-1:0][C-1:0][CB:0] y_t;
  typedef logic [R-1:0][C-1:0]       a_t;

  logic CLK = 1'b0;
  logic nRST;
  logic start;
  a_t   A;
  logic out_ready;
  logic busy;
  logic out_valid;
  y_t   Y;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  stoch_decode_mat #(
    .NUM_ROWS   (R),
    .NUM_COLS   (C),
    .COUNT_BITS (CB)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .A         (A),
    .out_ready (out_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .Y         (Y)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
  endtask

  // Reference model: a window is the W edges after the accepting edge; the
  // result is the plain sum of each element's bits over those edges.
  bit m_act, m_done;
  int m_n;
  y_t m_sum, m_y;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_act = 1'b0; m_done = 1'b0; m_n = 0; m_sum = '0; m_y = '0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_act) begin
      m_n++;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          m_sum[r][c] = m_sum[r][c] + (CB+1)'(A[r][c]);
      if (m_n == W) begin
        m_y = m_sum; m_act = 1'b0; m_done = 1'b1;
      end
    end else if (start) begin
      m_act = 1'b1; m_n = 0; m_sum = '0;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      check("cyc_busy",  64'(busy),      64'(m_act));
      check("cyc_valid", 64'(out_valid), 64'(m_done));
      check("cyc_y",     64'(Y),         64'(m_y));
    end
  end

  function automatic a_t a_pat(input int pid, input int k);
    a_t v;
    v = '0;
    case (pid)
      0: v = '1;
      1: v = '0;
      2: begin v[0][0] = (k % 2 == 0); v[1][1] = (k < 3); end
      default: v = a_t'($urandom);
    endcase
    return v;
  endfunction

  task automatic run_window(input int pid, input int hold, input bit restart, input int abort_at);
    int lat, bcnt;
    y_t yg, ysum, ylit;
    a_t av;
    lat = 0; bcnt = 0; ysum = '0;
    @(negedge CLK);
    start = 1'b1; out_ready = 1'b0; A = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      lat = i;
      if (busy) bcnt++;
      if (abort_at == i) begin
        #2 nRST = 1'b0;
        #1;
        check("abort_busy",  64'(busy),      64'(0));
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_y",     64'(Y),         64'(0));
        start = 1'b0; A = '0;
        @(negedge CLK);
        #2 nRST = 1'b1;
        return;
      end
      if (out_valid) break;
      av = (i <= W) ? a_pat(pid, i - 1) : '0;
      A = av;
      if (i <= W)
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            ysum[r][c] = ysum[r][c] + (CB+1)'(av[r][c]);
      start = restart && (i >= 6);
    end
    A = '0;
    check("latency",     64'(lat),  64'(W + 1));
    check("busy_cycles", 64'(bcnt), 64'(W));
    yg = Y;
    ylit = '0;
    case (pid)
      0: for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) ylit[r][c] = (CB+1)'(16);
      1: ylit = '0;
      2: begin ylit[0][0] = (CB+1)'(8); ylit[1][1] = (CB+1)'(3); end
      default: ylit = ysum;
    endcase
    check("result_y", 64'(yg), 64'(ylit));
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_y",     64'(Y),         64'(yg));
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0; start = 1'b0;
    check("release_valid", 64'(out_valid), 64'(0));
    check("release_busy",  64'(busy),      64'(0));
    if (restart)
      for (int j = 0; j < 3; j++) begin
        @(negedge CLK);
        check("no_restart", 64'(busy), 64'(0));
      end
  endtask

  initial begin
    nRST = 1'b1; start = 1'b0; A = '0; out_ready = 1'b0;
    #3 nRST = 1'b0;
    @(negedge CLK);
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_y",     64'(Y),         64'(0));
    #2 nRST = 1'b1;
    chk_on = 1'b1;

    run_window(0, 0, 1'b0, 0);   // all ones
    run_window(1, 0, 1'b0, 0);   // all zeros, immediate accept
    run_window(2, 0, 1'b0, 0);   // alternating / three ones
    run_window(0, 2, 1'b1, 0);   // start re-asserted mid-window and in DONE
    run_window(2, 5, 1'b0, 0);   // consumer stalls five cycles
    run_window(0, 0, 1'b0, 10);  // reset at window cycle 9
    run_window(0, 0, 1'b0, 0);   // fresh window after reset

    for (int n = 0; n < 8; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        @(negedge CLK);
        A = a_t'($urandom);
      end
      run_window(3, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 0);
    end

    @(negedge CLK);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stoch_decode_mat.md
STOCH_DECODE_MAT -- requirements
Module: stoch_decode_mat

Interface
REQ-001 The block SHALL have parameter NUM_ROWS, default 2: matrix rows.
REQ-002 The block SHALL have parameter NUM_COLS, default 2: matrix columns.
REQ-003 The block SHALL have parameter COUNT_BITS, default 8: decode window W = 2^COUNT_BITS cycles.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin a decode window.
REQ-007 The block SHALL have port A, input, [NUM_ROWS-1:0][NUM_COLS-1:0]: one stochastic bit per element per cycle, as produced by the stochastic matrix adder.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts Y.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a window is accumulating.
REQ-010 The block SHALL have port out_valid, output, 1 bit: Y holds a completed result.
REQ-011 The block SHALL have port Y, output, [NUM_ROWS-1:0][NUM_COLS-1:0][COUNT_BITS:0]: per-element count of ones over the window.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-013 IDLE -> ACCUM SHALL occur when start=1; this clears all accumulators and the window counter.
REQ-014 start SHALL be ignored in ACCUM and DONE.
REQ-015 In ACCUM, on each of the W cycles following the start cycle, every accumulator SHALL add its A bit.
REQ-016 The window counter SHALL increment once per ACCUM cycle.
REQ-017 On the ACCUM cycle where the window counter = W-1, Y SHALL load the accumulator plus the current A bit, and the state SHALL go to DONE.
REQ-018 out_valid SHALL be 1 exactly in DONE and SHALL first rise W+1 cycles after the cycle in which start was accepted.
REQ-019 DONE -> IDLE SHALL occur on a cycle with out_ready=1; out_valid and Y SHALL stay stable while out_ready=0.
REQ-020 If start=1 on the same cycle that DONE is left, start SHALL be ignored; a new window requires start while in IDLE.
REQ-021 Y SHALL hold its last loaded value in IDLE and ACCUM, and SHALL change only at the load in REQ-017.
REQ-022 Each accumulator and each Y element SHALL be COUNT_BITS+1 bits wide; the range 0..W SHALL be representable with no saturation or wrap.
REQ-023 busy SHALL be 1 exactly in ACCUM.
REQ-024 The window counter SHALL be COUNT_BITS bits wide and SHALL wrap from W-1 to 0 without any further effect.

Reset
REQ-025 While nRST=0, the state SHALL be IDLE, and the window counter and all accumulators SHALL be 0.
REQ-026 While nRST=0, busy SHALL be 0, out_valid SHALL be 0 and every Y element SHALL be 0.
REQ-027 Reset asserted mid-ACCUM or in DONE SHALL abort the operation with no result delivered.
REQ-028 After nRST deasserts, the first start SHALL begin a fresh window.

Structure
REQ-029 A shared package stoch_pkg SHALL hold the FSM state typedef (IDLE, ACCUM, DONE).
REQ-030 The control FSM and the window counter SHALL exist once and be shared by all elements.
REQ-031 The per-element accumulate-and-hold SHALL be a sub-module stoch_decode, instantiated NUM_ROWS x NUM_COLS times by nested generate loops.
REQ-032 stoch_decode SHALL take clear, enable and load controls from the shared FSM.

Verification
REQ-033 The bench SHALL cover: 2x2, COUNT_BITS=4, A all ones, start pulsed -> out_valid rises 17 cycles after start; all Y = 16.
REQ-034 The bench SHALL cover: A all zeros -> all Y = 0; out_valid asserted with out_ready=1 -> out_valid high for 1 cycle, then IDLE.
REQ-035 The bench SHALL cover: A[0][0] alternating 1/0, A[1][1] with exactly 3 ones, others 0 -> Y[0][0]=8, Y[1][1]=3, others 0.
REQ-036 The bench SHALL cover: start pulsed again at window cycle 5 and held high during DONE -> no restart, busy unchanged, single result.
REQ-037 The bench SHALL cover: out_ready=0 for 5 cycles in DONE -> out_valid and Y stable for all 5 cycles; released on the cycle out_ready=1.
REQ-038 The bench SHALL cover: nRST pulsed low at window cycle 9 -> outputs immediately 0, state IDLE; then a new start with all-ones A -> Y = 16.
